// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Operand magnitudes are computed on a 64-bit carrier, so WIDTH is limited to 64.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int MAX_WIDTH     = 64;

  // Counter width needed to count RUN iterations 0 .. w-1.
  function automatic int count_width(input int w);
    return $clog2(w);
  endfunction

  // Callers pass the operand sign-extended (signed) or zero-extended (unsigned);
  // the magnitude of -2^(W-1) comes out as 2^(W-1), which still fits in W bits.
  function automatic logic [MAX_WIDTH-1:0] abs_val(input logic [MAX_WIDTH-1:0] value,
                                                   input logic signed_mode);
    logic [MAX_WIDTH-1:0] result;
    if (signed_mode && value[MAX_WIDTH-1])
      result = ~value + 1'b1;
    else
      result = value;
    return result;
  endfunction

endpackage

// File: rtl/add_nbit.sv
// W-bit ripple-carry adder made of full-adder cells, with carry-in and carry-out.
module add_nbit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: magnitudes are multiplied over WIDTH RUN cycles
// and the sign is applied in a single FIX cycle. Handshake is start/busy/done.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     inp1,
  input  logic [WIDTH-1:0]     inp2,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = count_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

  state_t               state;
  logic [CNT_W-1:0]     count;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH-1:0]     acc_hi;
  logic                 sgn_mode;
  logic                 sign_diff;

  logic [MAX_WIDTH-1:0] ext1;
  logic [MAX_WIDTH-1:0] ext2;
  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic                 cout;
  logic [2*WIDTH-1:0]   acc_full;
  logic [2*WIDTH-1:0]   acc_neg;

  always_comb begin
    ext1 = MAX_WIDTH'(inp1);
    ext2 = MAX_WIDTH'(inp2);
    if (is_signed) begin
      ext1 = MAX_WIDTH'($signed(inp1));
      ext2 = MAX_WIDTH'($signed(inp2));
    end
  end

  assign addend   = mplier[0] ? mcand : '0;
  assign acc_full = {acc_hi, mplier};
  assign acc_neg  = ~acc_full + 1'b1;

  add_nbit #(.WIDTH(WIDTH)) u_add (
    .a    (acc_hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // The multiplier register doubles as the low half of the accumulator:
  // each RUN shift drops one consumed multiplier bit and takes in one product bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc_hi    <= '0;
      sgn_mode  <= 1'b0;
      sign_diff <= 1'b0;
      product   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sgn_mode  <= is_signed;
            sign_diff <= inp1[WIDTH-1] ^ inp2[WIDTH-1];
            mcand     <= WIDTH'(abs_val(ext1, is_signed));
            mplier    <= WIDTH'(abs_val(ext2, is_signed));
            acc_hi    <= '0;
            count     <= '0;
            state     <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc_hi <= {cout, sum[WIDTH-1:1]};
          mplier <= {sum[0], mplier[WIDTH-1:1]};
          count  <= count + 1'b1;
          if (count == LAST_COUNT)
            state <= FIX;
        end
        FIX: begin
          product <= (sgn_mode && sign_diff) ? acc_neg : acc_full;
          state   <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN) || (state == FIX);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier at WIDTH=8 and WIDTH=4.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;

  logic        start8, sgn8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic        start4, sgn4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .start     (start8),
    .is_signed (sgn8),
    .inp1      (a8),
    .inp2      (b8),
    .busy      (busy8),
    .done      (done8),
    .product   (p8)
  );

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .start     (start4),
    .is_signed (sgn4),
    .inp1      (a4),
    .inp2      (b4),
    .busy      (busy4),
    .done      (done4),
    .product   (p4)
  );

  // Issues one W=8 operation and waits (bounded) for done; returns at the done cycle.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     output logic [15:0] p, output int lat, output int busy_cycles);
    a8 = a; b8 = b; sgn8 = s; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    busy_cycles = 0;
    while (!done8 && lat < 50) begin
      if (busy8) busy_cycles++;
      @(posedge clk); #1;
      lat++;
    end
    p = p8;
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s,
                     output logic [7:0] p, output int lat);
    a4 = a; b4 = b; sgn4 = s; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    p = p4;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; sgn4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy8 !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy8); end
    checks++;
    if (done8 !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", done8); end
    checks++;
    if (p8 !== 16'h0000) begin fails++; $display("[TB] FAIL reset_product: got %h expected 0000", p8); end
    checks++;
    if ({busy4, done4, p4} !== 10'b0) begin
      fails++; $display("[TB] FAIL reset_w4: got busy=%b done=%b p=%h expected all zero", busy4, done4, p4);
    end
    rst = 1'b0;
  endtask

  task automatic test_unsigned_max();
    logic [15:0] p;
    int lat, bc;
    op8(8'hFF, 8'hFF, 1'b0, p, lat, bc);
    checks++;
    if (p !== 16'hFE01) begin fails++; $display("[TB] FAIL u255x255: got %h expected fe01", p); end
    checks++;
    if (lat != 9) begin fails++; $display("[TB] FAIL latency: got %0d expected 9", lat); end
    checks++;
    if (bc != 9) begin fails++; $display("[TB] FAIL busy_cycles: got %0d expected 9", bc); end
    @(posedge clk); #1;
    checks++;
    if (done8 !== 1'b0) begin fails++; $display("[TB] FAIL done_pulse: got %b expected 0", done8); end
    checks++;
    if (p8 !== 16'hFE01) begin fails++; $display("[TB] FAIL product_hold: got %h expected fe01", p8); end
  endtask

  task automatic test_signed();
    logic [7:0]  va [6] = '{8'h80, 8'h80, 8'hFF, 8'h00, 8'h80, 8'hFF};
    logic [7:0]  vb [6] = '{8'h80, 8'h7F, 8'h01, 8'hFB, 8'h80, 8'h01};
    logic        vs [6] = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0};
    logic [15:0] ve [6] = '{16'h4000, 16'hC080, 16'hFFFF, 16'h0000, 16'h4000, 16'h00FF};
    logic [15:0] p;
    int lat, bc;
    for (int i = 0; i < 6; i++) begin
      op8(va[i], vb[i], vs[i], p, lat, bc);
      checks++;
      if (p !== ve[i]) begin
        fails++;
        $display("[TB] FAIL mode_vec%0d: %h*%h s=%b got %h expected %h", i, va[i], vb[i], vs[i], p, ve[i]);
      end
    end
  endtask

  task automatic test_exhaustive_w4();
    logic [7:0] p, expv;
    int lat, ea, eb;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          ea = (s == 1 && a >= 8) ? a - 16 : a;
          eb = (s == 1 && b >= 8) ? b - 16 : b;
          expv = 8'(ea * eb);
          op4(4'(a), 4'(b), s[0], p, lat);
          checks++;
          if (p !== expv) begin
            fails++;
            $display("[TB] FAIL w4_%0dx%0d_s%0d: got %h expected %h (lat %0d)", a, b, s, p, expv, lat);
          end
          if (a == 15 && b == 15 && s == 0) begin
            checks++;
            if (p !== 8'd225) begin fails++; $display("[TB] FAIL w4_15x15: got %0d expected 225", p); end
          end
        end
      end
    end
  endtask

  task automatic test_busy_ignore();
    int ndone = 0;
    logic [15:0] pd = '0;
    a8 = 8'd6; b8 = 8'd7; sgn8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      start8 = busy8;
      a8 = 8'(i * 37 + 11);
      b8 = 8'(i + 3);
      sgn8 = i[0];
      if (done8) begin ndone++; pd = p8; end
      @(posedge clk); #1;
    end
    start8 = 1'b0;
    checks++;
    if (ndone != 1) begin fails++; $display("[TB] FAIL ignore_done_count: got %0d expected 1", ndone); end
    checks++;
    if (pd !== 16'd42) begin fails++; $display("[TB] FAIL ignore_product: got %0d expected 42", pd); end
  endtask

  task automatic test_reset_abort();
    logic [15:0] p;
    int lat, bc;
    int ndone = 0;
    a8 = 8'd9; b8 = 8'd10; sgn8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({busy8, done8} !== 2'b00) begin fails++; $display("[TB] FAIL abort_flags: got busy=%b done=%b expected 0 0", busy8, done8); end
    checks++;
    if (p8 !== 16'h0000) begin fails++; $display("[TB] FAIL abort_product: got %h expected 0000", p8); end
    for (int i = 0; i < 12; i++) begin
      if (done8) ndone++;
      @(posedge clk); #1;
    end
    checks++;
    if (ndone != 0) begin fails++; $display("[TB] FAIL abort_no_done: got %0d expected 0", ndone); end
    op8(8'd9, 8'd10, 1'b0, p, lat, bc);
    checks++;
    if (p !== 16'd90 || lat != 9) begin fails++; $display("[TB] FAIL after_abort: got %0d lat %0d expected 90 lat 9", p, lat); end
  endtask

  task automatic test_back_to_back();
    int d1 = -1, d2 = -1;
    logic [15:0] p1 = '0, p2 = '0, pmid = '0;
    a8 = 8'd3; b8 = 8'd5; sgn8 = 1'b0; start8 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin a8 = 8'd7; b8 = 8'd9; end
      if (done8) begin
        if (d1 < 0) begin
          d1 = c; p1 = p8;
        end else begin
          d2 = c; p2 = p8; start8 = 1'b0;
          break;
        end
      end else if (d1 >= 0) begin
        pmid = p8;
      end
    end
    start8 = 1'b0;
    checks++;
    if (d1 < 0 || d2 < 0 || d2 - d1 != 10) begin fails++; $display("[TB] FAIL b2b_spacing: got d1=%0d d2=%0d expected spacing 10", d1, d2); end
    checks++;
    if (p1 !== 16'd15) begin fails++; $display("[TB] FAIL b2b_first: got %0d expected 15", p1); end
    checks++;
    if (pmid !== 16'd15) begin fails++; $display("[TB] FAIL b2b_hold: got %0d expected 15", pmid); end
    checks++;
    if (p2 !== 16'd63) begin fails++; $display("[TB] FAIL b2b_second: got %0d expected 63", p2); end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed();
    test_exhaustive_w4();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
